fetch_exec_sequencer: RTL
=========================

Name: fetch_exec_sequencer

Overview:
- Control unit for the 4-bit accumulator processor.
- Steps each instruction through fetch, optional RAM wait states, and execute.
- Drives PC increment/load, the instruction/operand latch, ALU op select, accumulator and flag loads, data-bus source enables, RAM strobes and the output flip-flop load.
- Sits between program ROM/PC and the ALU/accumulator/RAM datapath; the existing phase output comes from here.

Parameters:
- WAIT_STATES, 0, extra RAM access cycles inserted before EXEC on memory-operand instructions (0..15).
- WAIT_W, 4, width of the wait-state counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- instr  in  4  opcode from instruction latch, valid from the cycle after fetch_en
- c_flag  in  1  carry flag
- z_flag  in  1  zero flag
- phase  out  1  0 = fetch, 1 = wait/execute
- fetch_en  out  1  latch program_byte into instr/oprnd at end of this cycle
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= {oprnd, program_byte} jump target
- alu_op  out  3  000 pass B, 001 sub, 010 add, 011 nand, 100 pass A
- acc_load  out  1  accumulator <= ALU result
- flags_load  out  1  c/z flags <= ALU flags
- oe_oprnd  out  1  immediate operand drives data_bus
- oe_ram  out  1  RAM drives data_bus
- oe_in  out  1  pushbuttons drive data_bus
- oe_alu  out  1  ALU result drives data_bus
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write strobe
- out_load  out  1  FF_out <= data_bus

Behaviour:
- Clock and reset: one clock, clock; reset asynchronous active-high. While reset is high, state = FETCH, wait counter = 0, and every output is 0, including phase.
- States: FETCH -> (memory opcode and WAIT_STATES>0 ? MEM_WAIT : EXEC) -> FETCH.
- FETCH: phase=0, fetch_en=1, all other strobes 0.
- MEM_WAIT: phase=1, ram_cs=1, oe_ram=1 except on ST, counter counts 0..WAIT_STATES-1, then EXEC. No acc/flag/PC strobes.
- EXEC: phase=1, exactly one cycle.
- Latency: 2 cycles per instruction, or 2+WAIT_STATES for memory opcodes (CMPM, LD, ST, NANDM, ADDM).
- Opcode decode in EXEC:
  - 0000 JC: pc_load if c_flag, else pc_inc.
  - 0001 JNC: pc_load if !c_flag, else pc_inc.
  - 0010 CMPI: oe_oprnd, alu_op=001, flags_load.
  - 0011 CMPM: ram_cs, oe_ram, alu_op=001, flags_load.
  - 0100 LIT: oe_oprnd, alu_op=000, acc_load.
  - 0101 IN: oe_in, alu_op=000, acc_load.
  - 0110 LD: ram_cs, oe_ram, alu_op=000, acc_load.
  - 0111 ST: alu_op=100, oe_alu, ram_cs, ram_we.
  - 1000 JZ / 1001 JNZ: as JC/JNC on z_flag.
  - 1010 NANDI / 1011 NANDM: immediate/RAM source, alu_op=011, acc_load, flags_load.
  - 1100 JMP: pc_load always.
  - 1101 OUT: alu_op=100, oe_alu, out_load.
  - 1110 ADDI / 1111 ADDM: immediate/RAM source, alu_op=010, acc_load, flags_load.
- PC rule: every non-jump EXEC asserts pc_inc. pc_inc and pc_load are never both 1.
- Bus rule: at most one oe_* is high in any cycle. All oe_* are 0 in FETCH.
- ram_we is high for exactly one cycle (EXEC of ST). ram_cs stays high continuously from the first MEM_WAIT cycle through EXEC.
- Flags are sampled only in EXEC of a conditional jump. Flags written by the previous instruction's EXEC are visible.
- Reset mid-instruction (any state): immediate return to FETCH with all strobes 0. No partial write: ram_we drops asynchronously.
- WAIT_STATES=0: MEM_WAIT is never entered.
- Outputs are combinational from the registered state and instr only. No combinational path from c_flag/z_flag except to pc_inc/pc_load.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined, two ports are added:
  - step_mode  in  1
  - step  in  1
- With step_mode=1, the sequencer holds in FETCH with fetch_en=0 until a rising edge of step (step synchronised internally, two flops), then completes exactly one instruction.
- step_mode=0 runs freely.
- Without the macro, there are no extra ports and the block always free-runs.

Test Plan:
- Reset held 3 cycles, then released with instr=0100 (LIT) -> phase sequence 0,1,0,1. In the EXEC cycle: oe_oprnd=1, alu_op=000, acc_load=1, pc_inc=1, flags_load=0.
- JC with c_flag=1 -> EXEC: pc_load=1, pc_inc=0. JC with c_flag=0 -> pc_inc=1, pc_load=0. JNZ with z_flag=0 -> pc_load=1.
- WAIT_STATES=2, instr=0111 (ST) -> FETCH, MEM_WAIT x2, EXEC. ram_cs high for 3 cycles. ram_we high only in the EXEC cycle. oe_alu=1, alu_op=100 in EXEC.
- WAIT_STATES=2, LD, reset asserted in the second MEM_WAIT cycle -> all outputs 0 immediately, no acc_load or pc_inc pulse. After release, the next cycle is FETCH with fetch_en=1.
- instr=1101 (OUT) then 0101 (IN) -> out_load with oe_alu, then acc_load with oe_in. A one-hot check over the oe_* outputs never fails over 200 random-opcode cycles.
- SEQ_SINGLE_STEP_EN defined, step_mode=1 -> sequencer stalls in FETCH with fetch_en=0. One step pulse -> exactly one FETCH+EXEC, then it stalls again.

Source files
------------

// File: rtl/fetch_exec_sequencer.sv
//-----------------------------------------------------------------------------
// fetch_exec_sequencer
//
// Control unit for the 4-bit accumulator processor. Steps every instruction
// through FETCH, optional RAM wait states (memory-operand opcodes only) and a
// single EXEC cycle. It drives all PC, latch, ALU, accumulator, flag,
// data-bus and RAM strobes.
//
// Parameters
//   WAIT_STATES  extra RAM access cycles before EXEC on memory opcodes (0..15)
//   WAIT_W       width of the wait-state counter
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   instr               opcode from the instruction latch (valid after fetch)
//   c_flag, z_flag      ALU flags, sampled only by conditional jumps in EXEC
//   phase               0 = fetch, 1 = wait/execute
//   fetch_en            latch program_byte into instr/oprnd at end of cycle
//   pc_inc, pc_load     PC increment / load jump target (mutually exclusive)
//   alu_op              000 pass B, 001 sub, 010 add, 011 nand, 100 pass A
//   acc_load, flags_load, out_load   register load strobes
//   oe_oprnd, oe_ram, oe_in, oe_alu  data-bus source enables (one-hot or zero)
//   ram_cs, ram_we      RAM chip select / write strobe
//
// Optional feature (macro SEQ_SINGLE_STEP_EN)
//   Adds step_mode and step inputs. With step_mode=1 the sequencer holds in
//   FETCH with fetch_en=0 until a synchronised rising edge of step, then runs
//   exactly one instruction.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_exec_sequencer #(
    parameter int WAIT_STATES = 0,
    parameter int WAIT_W      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] instr,
    input  logic       c_flag,
    input  logic       z_flag,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    output logic       phase,
    output logic       fetch_en,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [2:0] alu_op,
    output logic       acc_load,
    output logic       flags_load,
    output logic       oe_oprnd,
    output logic       oe_ram,
    output logic       oe_in,
    output logic       oe_alu,
    output logic       ram_cs,
    output logic       ram_we,
    output logic       out_load
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_EXEC     = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_JC    = 4'h0, OP_JNC   = 4'h1, OP_CMPI  = 4'h2, OP_CMPM  = 4'h3,
        OP_LIT   = 4'h4, OP_IN    = 4'h5, OP_LD    = 4'h6, OP_ST    = 4'h7,
        OP_JZ    = 4'h8, OP_JNZ   = 4'h9, OP_NANDI = 4'hA, OP_NANDM = 4'hB,
        OP_JMP   = 4'hC, OP_OUT   = 4'hD, OP_ADDI  = 4'hE, OP_ADDM  = 4'hF
    } opcode_e;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_NAND   = 3'b011;
    localparam logic [2:0] ALU_PASS_A = 3'b100;

    localparam logic [WAIT_W-1:0] LAST_WAIT =
        WAIT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    function automatic logic is_mem_op(input opcode_e o);
        return o inside {OP_CMPM, OP_LD, OP_ST, OP_NANDM, OP_ADDM};
    endfunction

    state_e              state_q, state_d, eff_state;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    opcode_e             op;
    logic                go;
    logic                taken;

    assign op = opcode_e'(instr);

    // The opcode is only latched at the end of FETCH, so the FETCH->next
    // decision cannot see it. With wait states configured, FETCH always moves
    // to S_MEM_WAIT; a non-memory opcode found there is treated as EXEC.
    assign eff_state = (state_q == S_MEM_WAIT && !is_mem_op(op)) ? S_EXEC : state_q;

`ifdef SEQ_SINGLE_STEP_EN
    logic [2:0] step_sync_q;   // [0],[1] synchroniser, [2] edge-detect history
    logic       step_pend_q, step_pend_d;
    logic       step_rise;

    assign step_rise   = step_sync_q[1] & ~step_sync_q[2];
    assign go          = ~step_mode | step_pend_q;
    // A pending step is consumed when FETCH actually fetches.
    assign step_pend_d = (step_pend_q | step_rise) & ~(eff_state == S_FETCH && go);
`else
    assign go = 1'b1;
`endif

    // Next-state logic.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (eff_state)
            S_FETCH: begin
                if (go) state_d = (WAIT_STATES > 0) ? S_MEM_WAIT : S_EXEC;
            end
            S_MEM_WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = S_EXEC;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of evaluation order.
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
`ifdef SEQ_SINGLE_STEP_EN
            step_sync_q <= '0;
            step_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef SEQ_SINGLE_STEP_EN
            step_sync_q <= {step_sync_q[1:0], step};
            step_pend_q <= step_pend_d;
`endif
        end
    end

    // Output decode. Gated by reset so every strobe (notably ram_we) drops
    // the moment reset rises, not at the next clock edge.
    always_comb begin
        phase      = 1'b0;
        fetch_en   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_op     = ALU_PASS_B;
        acc_load   = 1'b0;
        flags_load = 1'b0;
        oe_oprnd   = 1'b0;
        oe_ram     = 1'b0;
        oe_in      = 1'b0;
        oe_alu     = 1'b0;
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        out_load   = 1'b0;
        taken      = 1'b0;
        if (!reset) begin
            case (eff_state)
                S_FETCH: fetch_en = go;
                S_MEM_WAIT: begin
                    phase  = 1'b1;
                    ram_cs = 1'b1;
                    oe_ram = (op != OP_ST);
                end
                default: begin
                    phase = 1'b1;
                    case (op)
                        OP_JC:    taken = c_flag;
                        OP_JNC:   taken = ~c_flag;
                        OP_JZ:    taken = z_flag;
                        OP_JNZ:   taken = ~z_flag;
                        OP_JMP:   taken = 1'b1;
                        OP_CMPI:  begin oe_oprnd = 1'b1; alu_op = ALU_SUB; flags_load = 1'b1; end
                        OP_CMPM:  begin ram_cs = 1'b1; oe_ram = 1'b1; alu_op = ALU_SUB; flags_load = 1'b1; end
                        OP_LIT:   begin oe_oprnd = 1'b1; acc_load = 1'b1; end
                        OP_IN:    begin oe_in = 1'b1; acc_load = 1'b1; end
                        OP_LD:    begin ram_cs = 1'b1; oe_ram = 1'b1; acc_load = 1'b1; end
                        OP_ST:    begin alu_op = ALU_PASS_A; oe_alu = 1'b1; ram_cs = 1'b1; ram_we = 1'b1; end
                        OP_NANDI: begin oe_oprnd = 1'b1; alu_op = ALU_NAND; acc_load = 1'b1; flags_load = 1'b1; end
                        OP_NANDM: begin ram_cs = 1'b1; oe_ram = 1'b1; alu_op = ALU_NAND; acc_load = 1'b1; flags_load = 1'b1; end
                        OP_OUT:   begin alu_op = ALU_PASS_A; oe_alu = 1'b1; out_load = 1'b1; end
                        OP_ADDI:  begin oe_oprnd = 1'b1; alu_op = ALU_ADD; acc_load = 1'b1; flags_load = 1'b1; end
                        default:  begin ram_cs = 1'b1; oe_ram = 1'b1; alu_op = ALU_ADD; acc_load = 1'b1; flags_load = 1'b1; end
                    endcase
                    // Non-jumps never set taken, so they always increment.
                    pc_load = taken;
                    pc_inc  = ~taken;
                end
            endcase
        end
    end

endmodule
